// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers.
//   arb_state_t  : grant controller state (IDLE, GRANT, GAP)
//   arb_struct_t : record carried through the arbiter mux downstream
//   rr_pick_t    : {found, idx} result of a round-robin pick
//   idx_width()  : clog2 with a minimum of 1, for index/counter widths
//   rr_pick()    : round-robin find-first starting at ptr, wrapping modulo n
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int MAX_SOURCES = 32;
    localparam int MAX_IDX_W   = 5;

    // Record selected by the arbiter mux; src identifies the granted source.
    typedef struct packed {
        logic [MAX_IDX_W-1:0] src;
        logic [31:0]          data;
    } arb_struct_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First set bit at ptr, ptr+1, ... wrapping modulo n (n <= MAX_SOURCES, ptr < n).
    // Scanning downward lets the lowest rotated offset win.
    function automatic rr_pick_t rr_pick(input logic [MAX_SOURCES-1:0] req,
                                         input int n, input int ptr);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int i = MAX_SOURCES - 1; i >= 0; i--) begin
            if (i < n) begin
                j = ptr + i;
                if (j >= n) j = j - n;
                if (req[j]) begin
                    r.found = 1'b1;
                    r.idx   = MAX_IDX_W'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: rotate req so ptr lands at bit 0,
// find the first set bit, then map the offset back to a source index.
//   req   : per-source request levels
//   ptr   : highest-priority source this round
//   found : at least one request is set
//   idx   : selected source (valid when found)
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter  int SOURCES = 4,
    localparam int IDX_W   = idx_width(SOURCES)
) (
    input  logic [SOURCES-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [SOURCES-1:0] rot;
    int                 src;
    int                 off;

    always_comb begin
        rot   = '0;
        src   = 0;
        off   = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < SOURCES; i++) begin
            src = int'(ptr) + i;
            if (src >= SOURCES) src = src - SOURCES;
            rot[i] = req[src];
        end
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        found = |rot;
        src   = int'(ptr) + off;
        if (src >= SOURCES) src = src - SOURCES;
        idx = IDX_W'(src);
    end

endmodule

// File: rtl/arb_grant_ctrl.sv
// Round-robin grant controller feeding the arbiter mux enable vector.
//   clk       : rising-edge clock
//   n_rst     : asynchronous active-low reset
//   req       : per-source request levels, held until served
//   done      : consumer finished with the current record (used only in GRANT)
//   n_mult_en : registered one-hot-or-zero enable vector
//   grant_idx : index of the active grant (valid while busy)
//   busy      : a grant is active
//   timeout   : one-cycle pulse when a grant is force-released after MAX_HOLD cycles
// Handshake: a source owns the mux from the cycle its enable rises until the
// cycle after done (or withdrawal/timeout) is sampled; every release is followed
// by exactly one all-zero cycle before the next enable can rise.
module arb_grant_ctrl
    import arb_pkg::*;
#(
    parameter  int SOURCES  = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDX_W    = idx_width(SOURCES)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [SOURCES-1:0] req,
    input  logic               done,
    output logic [SOURCES-1:0] n_mult_en,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               busy,
    output logic               timeout
);

    localparam int HOLD_W = idx_width(MAX_HOLD + 1);

    // state is the observable FSM state for debug and checkers.
    arb_state_t         state;
    arb_state_t         state_next;
    logic               run;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_next;
    logic [SOURCES-1:0] en_next;
    logic [IDX_W-1:0]   idx_next;
    logic               busy_next;
    logic               timeout_next;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               hold_expired;
    logic               release_now;

    rr_priority_pick #(.SOURCES(SOURCES)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Reset release is re-timed to the clock: the FSM stays frozen for the first
    // edge after n_rst rises, so the first arbitration is on the second edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) run <= 1'b0;
        else        run <= 1'b1;
    end

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        hold_next    = hold_cnt;
        en_next      = n_mult_en;
        idx_next     = grant_idx;
        busy_next    = busy;
        timeout_next = 1'b0;
        release_now  = 1'b0;
        hold_expired = (MAX_HOLD != 0) && (int'(hold_cnt) == MAX_HOLD - 1);

        unique case (state)
            IDLE, GAP: begin
                if (pick_found) begin
                    state_next        = GRANT;
                    en_next           = '0;
                    en_next[pick_idx] = 1'b1;
                    idx_next          = pick_idx;
                    busy_next         = 1'b1;
                    hold_next         = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (int'(hold_cnt) < MAX_HOLD) hold_next = hold_cnt + 1'b1;
                // done outranks withdrawal, which outranks the hold limit.
                release_now = done || !req[grant_idx] || hold_expired;
                if (release_now) begin
                    state_next   = GAP;
                    en_next      = '0;
                    busy_next    = 1'b0;
                    ptr_next     = (int'(grant_idx) == SOURCES - 1) ? '0 : grant_idx + 1'b1;
                    timeout_next = !done && req[grant_idx];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            n_mult_en <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else if (run) begin
            state     <= state_next;
            ptr       <= ptr_next;
            hold_cnt  <= hold_next;
            n_mult_en <= en_next;
            grant_idx <= idx_next;
            busy      <= busy_next;
            timeout   <= timeout_next;
        end
    end

    // Simulation-only consistency check of the grant outputs.
    a_grant_consistent: assert property (@(posedge clk) disable iff (!n_rst)
        $onehot0(n_mult_en) && (busy == (|n_mult_en)) && (!busy || n_mult_en[grant_idx]))
        else $error("arb_grant_ctrl: enable vector, busy and grant_idx disagree");

endmodule

// File: doc/arb_grant_ctrl.md
Name: arb_grant_ctrl

Overview:
- Round-robin grant generator that drives the one-hot enable vector consumed by the arbiter mux.
- Takes per-source request lines and a completion strobe from the downstream consumer of the arbitrated struct.
- Issues exactly one registered enable at a time (or none), with break-before-make sequencing and an optional hold timeout.
- Sits between the request sources and the arbiter mux.

Parameters:
- SOURCES, 4: number of requesting sources (>=1).
- MAX_HOLD, 16: max cycles one grant is held before forced release; 0 disables the timeout.
- IDX_W, $clog2(SOURCES) (min 1): width of grant_idx; derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- req  in  SOURCES  per-source request; level, held until served.
- done  in  1  consumer finished with current struct; sampled only while granting.
- n_mult_en  out  SOURCES  one-hot-or-zero grant vector to the arbiter mux; registered.
- grant_idx  out  IDX_W  index of the active grant; valid when busy=1.
- busy  out  1  a grant is active (OR of n_mult_en).
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (n_rst=0, async): n_mult_en=0, grant_idx=0, busy=0, timeout=0, rr pointer=0, hold_cnt=0, state=IDLE. Deassertion is synchronised internally; first arbitration occurs on the 2nd rising edge after release.
- States:
  - IDLE: no grant.
  - GRANT: one enable high.
  - GAP: exactly one cycle with all enables low after every release.
- IDLE/GAP arbitration:
  - Select the first set req bit at index ptr, ptr+1, ..., wrapping modulo SOURCES.
  - If found: at the next edge, set n_mult_en[sel]=1, grant_idx=sel, busy=1, hold_cnt=0, state=GRANT.
  - Otherwise: state=IDLE.
- Latency: req seen high at edge N -> n_mult_en high after edge N (visible in cycle N+1).
- GRANT: hold_cnt increments each cycle, saturating at MAX_HOLD. Release is evaluated in priority order:
  1. done=1 -> normal release, timeout stays 0.
  2. req[grant_idx]=0 -> requester withdrew, normal release.
  3. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> forced release, timeout=1 for one cycle, coincident with the cleared enable.
- On release edge: n_mult_en=0, busy=0, ptr=(grant_idx+1) mod SOURCES, state=GAP.
- GAP: identical to IDLE arbitration. A new grant is therefore never adjacent to the previous one; minimum one zero-enable cycle.
- Simultaneous done and timeout condition: treated as done; no timeout pulse.
- done while IDLE/GAP: ignored.
- Requests arriving during GRANT: queued by level only; no latching.
- A source that drops req before being granted is simply skipped.
- SOURCES=1: ptr fixed at 0. The single source is re-granted after each GAP if still requesting.
- Invariant: $onehot0(n_mult_en) every cycle; busy == |n_mult_en; grant_idx matches the set bit. Check with a concurrent assertion (simulation only) that fires an error on violation.
- hold_cnt width: $clog2(MAX_HOLD+1), min 1.
- All outputs come directly from flops; no combinational input-to-output paths.

Decomposition:
- Shared package arb_pkg holds:
  - arb_struct_t
  - the state enum (IDLE, GRANT, GAP)
  - a localparam function for the index width (clog2 with min 1)
- Also in arb_pkg: a pure function rr_pick(req, ptr) returning {found, idx}, reused by future arbiters.
- One sub-module is natural: rr_priority_pick, the combinational rotate / find-first / unrotate used in IDLE/GAP. Everything else stays in arb_grant_ctrl.

Test Plan:
- Reset mid-grant: SOURCES=4, req=4'b0100 granted, then n_rst low for 3 cycles -> n_mult_en=0 immediately (async); after release and req=4'b0001, grant to source 0, since ptr reset to 0.
- Round-robin fairness: req=4'b1111 held, done pulsed 1 cycle after each grant -> grant order 0,1,2,3,0; exactly one zero cycle between grants; never two bits set.
- Timeout: MAX_HOLD=8, req=4'b0010 held, done never -> n_mult_en=4'b0010 for exactly 8 cycles; timeout=1 on the cycle enables clear; regrant to source 1 after 1 GAP cycle.
- done coincident with timeout: assert done in the 8th grant cycle -> release occurs, timeout stays 0.
- Withdrawal and skip: grant to 2, req=4'b1100, drop req[2] -> release next edge, ptr=3, next grant to 3; req[1] pulsed only during GRANT is never granted.
- SOURCES=1, MAX_HOLD=0: req=1 constant, done every 5th cycle -> enable pattern high 5 cycles / low 1 cycle; timeout never asserted; grant_idx=0.
